// File: rtl/cart_mem_arbiter_if.sv
// Signal bundle between the cartridge ROM arbiter, its three requesters
// (ROM download writer, gb1 cart, gb2 cart) and the single-port ROM store.
interface cart_mem_arbiter_if #(parameter int ADDR_W = 24);
  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [15:0]       dl_data;
  logic              dl_ack;
  logic              gb1_req,  gb2_req;
  logic [ADDR_W-1:0] gb1_addr, gb2_addr;
  logic              gb1_ack,  gb2_ack;
  logic [15:0]       gb1_data, gb2_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_we, mem_rd;
  logic [15:0]       mem_dout;
  logic              busy;

  modport slave (
    input  dl_req, dl_addr, dl_data, gb1_req, gb1_addr, gb2_req, gb2_addr, mem_dout,
    output dl_ack, gb1_ack, gb2_ack, gb1_data, gb2_data, mem_addr, mem_din, mem_we, mem_rd, busy
  );
  modport master (
    output dl_req, dl_addr, dl_data, gb1_req, gb1_addr, gb2_req, gb2_addr, mem_dout,
    input  dl_ack, gb1_ack, gb2_ack, gb1_data, gb2_data, mem_addr, mem_din, mem_we, mem_rd, busy
  );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Serialises download writes and gb1/gb2 cart reads onto one single-port ROM:
// download has fixed priority, the two carts share round-robin.
module cart_mem_arbiter #(
  parameter int ADDR_W = 24,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  cart_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        gb_req;
  logic [ADDR_W-1:0] gb_addr [2];
  logic              grant, sel_gb, cap;
  logic              gnt_dl, gnt_gb, last_gb;
  logic [2:0]        cnt;
  logic              dl_ack_q, mem_we_q, mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_din_q;
  logic              gb_ack_q  [2];
  logic [15:0]       gb_data_q [2];

  assign gb_req     = {bus.gb2_req, bus.gb1_req};
  assign gb_addr[0] = bus.gb1_addr;
  assign gb_addr[1] = bus.gb2_addr;
  assign grant      = bus.dl_req | (|gb_req);
  // On a tie the cart not served last wins; last_gb=1 means gb2 was last.
  assign sel_gb     = (&gb_req) ? ~last_gb : gb_req[1];
  assign cap        = (state == WAIT) && (cnt == 3'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = gnt_dl ? DONE : WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      gnt_dl     <= 1'b0;
      gnt_gb     <= 1'b0;
      last_gb    <= 1'b1;
      cnt        <= 3'd0;
      dl_ack_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
      dl_ack_q <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          gnt_dl   <= bus.dl_req;
          gnt_gb   <= sel_gb;
          mem_we_q <= bus.dl_req;
          mem_rd_q <= ~bus.dl_req;
          if (bus.dl_req) begin
            mem_addr_q <= bus.dl_addr;
            mem_din_q  <= bus.dl_data;
          end else begin
            mem_addr_q <= gb_addr[sel_gb];
            last_gb    <= sel_gb;
          end
        end
        ISSUE: begin
          cnt      <= 3'(RD_LAT - 1);
          dl_ack_q <= gnt_dl;
        end
        WAIT:    cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Per-cart read-data register and ack, loaded in the capture cycle.
  for (genvar p = 0; p < 2; p++) begin : g_port
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        gb_ack_q[p]  <= 1'b0;
        gb_data_q[p] <= '0;
      end else begin
        gb_ack_q[p] <= cap && (gnt_gb == 1'(p));
        if (cap && (gnt_gb == 1'(p))) gb_data_q[p] <= bus.mem_dout;
      end
    end
  end

  assign bus.dl_ack   = dl_ack_q;
  assign bus.gb1_ack  = gb_ack_q[0];
  assign bus.gb2_ack  = gb_ack_q[1];
  assign bus.gb1_data = gb_data_q[0];
  assign bus.gb2_data = gb_data_q[1];
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed plan cases, random traffic checked by a
// scoreboard and arbitration model, plus RD_LAT=1/7 spacing sweep instances.
module tb_cart_mem_arbiter;
  localparam int AW  = 24;
  localparam int LAT = 2;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int ntests = 0;
  int nfail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  cart_mem_arbiter_if #(.ADDR_W(AW)) bus();
  cart_mem_arbiter #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus.slave));

  // ROM store environment: 4K words, preset to ~addr, RD_LAT-deep read pipe.
  logic [15:0] mem_arr [4096];
  logic [15:0] md [LAT];
  initial for (int i = 0; i < 4096; i++) mem_arr[i] <= ~16'(i);
  always @(posedge clk_sys) begin
    if (bus.mem_we) mem_arr[bus.mem_addr[11:0]] <= bus.mem_din;
    md[0] <= bus.mem_rd ? mem_arr[bus.mem_addr[11:0]] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) md[i] <= md[i-1];
  end
  assign bus.mem_dout = md[LAT-1];

  // Reference model: ROM content is ~addr unless the download wrote it.
  logic [15:0] ref_w [int];
  function automatic logic [15:0] ref_read(logic [23:0] a);
    if (ref_w.exists(int'(a))) return ref_w[int'(a)];
    return ~a[15:0];
  endfunction

  logic [15:0] q1[$], q2[$];
  int dl_pend = 0;
  int ack_log[$];
  int n_ack = 0, n_strobe = 0, last_m = 2;

  typedef struct packed {
    logic [2:0]  req;
    logic        we, rd;
    logic [23:0] maddr, a0, a1, a2;
  } snap_t;
  snap_t hist[$];

  // Monitor: per ack, find the grant cycle from the documented latency and
  // check winner, strobe, address and data against the model.
  initial begin
    snap_t s, g, iss;
    logic [2:0] acks;
    int port, nidx, pred;
    logic [23:0] ra;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        hist.delete(); last_m = 2; n_ack = 0; n_strobe = 0;
      end else begin
        s.req = {bus.gb2_req, bus.gb1_req, bus.dl_req};
        s.we = bus.mem_we; s.rd = bus.mem_rd; s.maddr = bus.mem_addr;
        s.a0 = bus.dl_addr; s.a1 = bus.gb1_addr; s.a2 = bus.gb2_addr;
        hist.push_back(s);
        if (bus.mem_we || bus.mem_rd) begin
          n_strobe++;
          check("strobe_overlap", 32'(bus.mem_we & bus.mem_rd), 32'd0);
        end
        acks = {bus.gb2_ack, bus.gb1_ack, bus.dl_ack};
        if (acks != 3'b000) begin
          n_ack++;
          check("ack_onehot", 32'($onehot(acks)), 32'd1);
          port = acks[0] ? 0 : (acks[1] ? 1 : 2);
          ack_log.push_back(port);
          nidx = hist.size() - 1 - ((port == 0) ? 2 : 2 + LAT);
          if (nidx < 0) check("ack_without_grant", 32'd1, 32'd0);
          else begin
            g = hist[nidx]; iss = hist[nidx+1];
            if (g.req[0])             pred = 0;
            else if (&g.req[2:1])     pred = (last_m == 2) ? 1 : 2;
            else if (g.req[1])        pred = 1;
            else if (g.req[2])        pred = 2;
            else                      pred = 7;
            check("arb_winner", 32'(port), 32'(pred));
            check("strobe_kind", 32'(port == 0 ? iss.we : iss.rd), 32'd1);
            ra = (port == 0) ? g.a0 : ((port == 1) ? g.a1 : g.a2);
            check("mem_addr_at_issue", 32'(iss.maddr), 32'(ra));
          end
          if (port == 0) begin
            check("dl_ack_expected", 32'(dl_pend > 0), 32'd1);
            if (dl_pend > 0) dl_pend--;
          end else if (port == 1) begin
            if (q1.size() == 0) check("gb1_unexpected_ack", 32'd1, 32'd0);
            else check("gb1_data", 32'(bus.gb1_data), 32'(q1.pop_front()));
          end else begin
            if (q2.size() == 0) check("gb2_unexpected_ack", 32'd1, 32'd0);
            else check("gb2_data", 32'(bus.gb2_data), 32'(q2.pop_front()));
          end
          if (port != 0) last_m = port;
        end
      end
    end
  end

  function automatic logic ack_of(int p);
    return (p == 0) ? bus.dl_ack : ((p == 1) ? bus.gb1_ack : bus.gb2_ack);
  endfunction

  task automatic set_gb(input int p, input logic r, input logic [23:0] a);
    if (p == 1) begin bus.gb1_addr = a; bus.gb1_req = r; end
    else        begin bus.gb2_addr = a; bus.gb2_req = r; end
  endtask

  task automatic wait_ack(input int p);
    int t = 0;
    do begin @(negedge clk_sys); t++; end while (!ack_of(p) && t < 400);
    check("ack_arrives", 32'(ack_of(p)), 32'd1);
  endtask

  task automatic do_gb(input int p, input logic [23:0] a);
    if (p == 1) q1.push_back(ref_read(a)); else q2.push_back(ref_read(a));
    set_gb(p, 1'b1, a);
    wait_ack(p);
    @(posedge clk_sys); #1;
    set_gb(p, 1'b0, a);
  endtask

  task automatic do_dl(input logic [23:0] a, input logic [15:0] d);
    ref_w[int'(a)] = d;
    dl_pend++;
    bus.dl_addr = a; bus.dl_data = d; bus.dl_req = 1'b1;
    wait_ack(0);
    @(posedge clk_sys); #1;
    bus.dl_req = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_dl_ack",   32'(bus.dl_ack),   32'd0);
    check("rst_gb1_ack",  32'(bus.gb1_ack),  32'd0);
    check("rst_gb2_ack",  32'(bus.gb2_ack),  32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_din",  32'(bus.mem_din),  32'd0);
    check("rst_gb1_data", 32'(bus.gb1_data), 32'd0);
    check("rst_gb2_data", 32'(bus.gb2_data), 32'd0);
  endtask

  // RD_LAT sweep: gb1 holds req on a fixed address; acks every 3+RD_LAT cycles.
  bit sw_go = 1'b0;
  bit sw_done [2];
  for (genvar k = 0; k < 2; k++) begin : g_sw
    localparam int L  = (k == 0) ? 1 : 7;
    localparam int SP = 3 + L;
    cart_mem_arbiter_if #(.ADDR_W(AW)) sif();
    cart_mem_arbiter #(.ADDR_W(AW), .RD_LAT(L)) u_dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .bus(sif.slave));
    logic [15:0] sd [L];
    always @(posedge clk_sys) begin
      sd[0] <= sif.mem_rd ? ~sif.mem_addr[15:0] : 16'hDEAD;
      for (int i = 1; i < L; i++) sd[i] <= sd[i-1];
    end
    assign sif.mem_dout = sd[L-1];
    initial begin
      int last, t, n;
      logic [23:0] a;
      logic [15:0] expq[$];
      sif.dl_req = 1'b0; sif.dl_addr = '0; sif.dl_data = '0;
      sif.gb1_req = 1'b0; sif.gb1_addr = '0; sif.gb2_req = 1'b0; sif.gb2_addr = '0;
      sw_done[k] = 1'b0;
      wait (sw_go);
      @(posedge clk_sys); #1;
      a = 24'h000300 + 24'(k * 'h111);
      for (int i = 0; i < 4; i++) expq.push_back(~a[15:0]);
      sif.gb1_addr = a; sif.gb1_req = 1'b1;
      n = 0; last = -1; t = 0;
      while (n < 4 && t < 200) begin
        @(negedge clk_sys); t++;
        if (sif.gb1_ack) begin
          if (expq.size() > 0) check("sweep_data", 32'(sif.gb1_data), 32'(expq.pop_front()));
          if (last >= 0) check("sweep_spacing", 32'(t - last), 32'(SP));
          last = t; n++;
        end
      end
      check("sweep_ack_count", 32'(n), 32'd4);
      @(posedge clk_sys); #1;
      sif.gb1_req = 1'b0;
      sw_done[k] = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [6] = '{1, 2, 1, 2, 1, 2};
    int t;
    bus.dl_req = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.gb1_req = 1'b0; bus.gb1_addr = '0; bus.gb2_req = 1'b0; bus.gb2_addr = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys); #1;
    chk_reset();
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys); #1;

    // Single gb1 read of 0x123 with exact cycle timing.
    q1.push_back(ref_read(24'h000123));
    set_gb(1, 1'b1, 24'h000123);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("t1_mem_rd",   32'(bus.mem_rd),   32'd1);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'h123);
    check("t1_busy",     32'(bus.busy),     32'd1);
    repeat (2) @(negedge clk_sys);
    check("t1_no_early_ack", 32'(bus.gb1_ack), 32'd0);
    @(negedge clk_sys);
    check("t1_gb1_ack",  32'(bus.gb1_ack),  32'd1);
    check("t1_gb1_data", 32'(bus.gb1_data), 32'hFEDC);
    check("t1_gb2_data", 32'(bus.gb2_data), 32'd0);
    @(posedge clk_sys); #1;
    set_gb(1, 1'b0, 24'h000123);

    // Write 0xA55A to 0x10, then read it back on gb2.
    ref_w[32'h10] = 16'hA55A;
    dl_pend++;
    bus.dl_addr = 24'h10; bus.dl_data = 16'hA55A; bus.dl_req = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("t2_mem_we",   32'(bus.mem_we),   32'd1);
    check("t2_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("t2_mem_din",  32'(bus.mem_din),  32'hA55A);
    @(negedge clk_sys);
    check("t2_mem_we_one_cycle", 32'(bus.mem_we), 32'd0);
    check("t2_dl_ack",   32'(bus.dl_ack),   32'd1);
    @(posedge clk_sys); #1;
    bus.dl_req = 1'b0;
    @(negedge clk_sys);
    check("t2_dl_ack_pulse", 32'(bus.dl_ack), 32'd0);
    @(posedge clk_sys); #1;
    do_gb(2, 24'h10);
    check("t2_readback", 32'(bus.gb2_data), 32'hA55A);

    // All three requests rise together: order dl, gb1, gb2.
    ack_log.delete();
    fork
      do_dl(24'h20, 16'h1234);
      do_gb(1, 24'h0AB);
      do_gb(2, 24'h0CD);
    join
    check("prio_count", 32'(ack_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < ack_log.size(); i++)
      check("prio_order", 32'(ack_log[i]), 32'(i));

    // Both carts held high for six grants: strict alternation.
    ack_log.delete();
    for (int i = 0; i < 3; i++) begin
      q1.push_back(ref_read(24'h40));
      q2.push_back(ref_read(24'h41));
    end
    set_gb(1, 1'b1, 24'h40);
    set_gb(2, 1'b1, 24'h41);
    fork
      begin
        for (int i = 0; i < 3; i++) wait_ack(1);
        @(posedge clk_sys); #1; set_gb(1, 1'b0, 24'h40);
      end
      begin
        for (int i = 0; i < 3; i++) wait_ack(2);
        @(posedge clk_sys); #1; set_gb(2, 1'b0, 24'h41);
      end
    join
    check("rr_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check("rr_order", 32'(ack_log[i]), 32'(rr_exp[i]));
    check("strobes_match_acks", 32'(n_strobe), 32'(n_ack));

    // Reset while a gb1 read is waiting for data.
    q1.push_back(ref_read(24'h55));
    set_gb(1, 1'b1, 24'h55);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk_reset();
    set_gb(1, 1'b0, 24'h55);
    q1.delete();
    repeat (2) begin
      @(negedge clk_sys);
      check("rst_hold_no_ack", 32'(bus.gb1_ack), 32'd0);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    ack_log.delete();
    fork
      do_gb(1, 24'h60);
      do_gb(2, 24'h61);
    join
    check("post_rst_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() > 0) check("post_rst_gb1_first", 32'(ack_log[0]), 32'd1);

    // Random traffic: dl writes in 0x800.., carts read 0..0x7FF.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk_sys); #1;
          do_dl(24'h800 | 24'($urandom_range(0, 255)), 16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_sys); #1;
          do_gb(1, 24'($urandom_range(0, 2047)));
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_sys); #1;
          do_gb(2, 24'($urandom_range(0, 2047)));
        end
      end
    join

    // Random reads of the words the download wrote.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); #1;
      do_gb(1 + (i % 2), 24'h800 | 24'($urandom_range(0, 255)));
    end

    repeat (8) @(posedge clk_sys); #1;
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    check("final_q2_empty", 32'(q2.size()), 32'd0);
    check("final_dl_pend",  32'(dl_pend),   32'd0);
    check("final_strobes_match_acks", 32'(n_strobe), 32'(n_ack));
    check("final_idle", 32'(bus.busy), 32'd0);

    sw_go = 1'b1;
    t = 0;
    while (!(sw_done[0] && sw_done[1]) && t < 500) begin
      @(posedge clk_sys); t++;
    end
    check("sweep_finished", 32'(sw_done[0] && sw_done[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
